mat_add_ctrl: RTL and testbench

Sequencer that performs element-wise addition of two SIZE_A x SIZE_B signed matrices held in external single-port RAMs. It replaces the fully parallel matrix adder wherever area matters: one shared N_BITS adder, streamed row-major. It sits between the matrix storage RAMs and the downstream consumer of the result matrix. It issues read addresses, adds the returned operands, and writes N_BITS+1-bit sums to a result RAM, signalling completion with a one-cycle pulse.

---
 rtl/mat_pkg.sv | 22 ++
 rtl/mat_addr_gen.sv | 38 +++
 rtl/mat_add_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mat_add_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared definitions for the streamed matrix adder: sequencer states and the
// address-width helper used to size every element index.
package mat_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Index width for a size_a x size_b matrix; never narrower than one bit so a
  // 1x1 matrix still has a legal address port.
  function automatic int calc_aw(input int size_a, input int size_b);
    int n_el;
    int aw;
    n_el = size_a * size_b;
    aw   = $clog2(n_el);
    return (aw < 1) ? 1 : aw;
  endfunction

endpackage

// File: rtl/mat_addr_gen.sv
// Row-major element index counter for the matrix adder. Loads to zero, counts
// up on request and parks at NUM_EL-1 (it never wraps); o_tc flags the last
// index.
module mat_addr_gen #(
  parameter int NUM_EL = 64,
  parameter int AW     = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_inc,
  output logic [AW-1:0] o_addr,
  output logic          o_tc
);

  localparam logic [AW-1:0] LAST = AW'(NUM_EL - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] ZERO = AW'(0);

  logic [AW-1:0] r_addr;

  // Index register: clear on load, step while enabled, hold at the last index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr <= ZERO;
    end else if (i_load) begin
      r_addr <= ZERO;
    end else if (i_inc && (r_addr != LAST)) begin
      r_addr <= r_addr + ONE;
    end else begin
      r_addr <= r_addr;
    end
  end

  assign o_addr = r_addr;
  assign o_tc   = (r_addr == LAST);

endmodule

// File: rtl/mat_add_ctrl.sv
// Streamed element-wise adder for two SIZE_A x SIZE_B signed matrices held in
// external RAMs. One shared adder, one element per cycle, row-major order.
// Read at cycle k+1, operands arrive at k+2, result written at k+3.
// Optional build macro MAT_ADD_SUB_EN adds the 'sub' port (a - b when set,
// captured together with start and held for the whole operation).
module mat_add_ctrl
  import mat_pkg::*;
#(
  parameter  int SIZE_A = 8,
  parameter  int SIZE_B = 8,
  parameter  int N_BITS = 32,
  localparam int NUM_EL = SIZE_A * SIZE_B,
  localparam int AW     = calc_aw(SIZE_A, SIZE_B)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [AW-1:0]            rd_addr,
  input  logic signed [N_BITS-1:0] a_data,
  input  logic signed [N_BITS-1:0] b_data,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic signed [N_BITS:0]   wr_data
`ifdef MAT_ADD_SUB_EN
  ,
  input  logic                     sub
`endif
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_drain;
  logic                   w_load;
  logic                   w_inc;
  logic                   w_tc;
  logic [AW-1:0]          w_addr;
  logic                   r_rd_en;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_s2_en;
  logic [AW-1:0]          r_s2_addr;
  logic                   r_wr_en;
  logic [AW-1:0]          r_wr_addr;
  logic signed [N_BITS:0] r_wr_data;
  logic signed [N_BITS:0] w_a_ext;
  logic signed [N_BITS:0] w_b_ext;
  logic signed [N_BITS:0] w_sum;

  assign w_load = (r_state == IDLE) && start;
  assign w_inc  = (r_state == RUN) && !w_tc;

  mat_addr_gen #(
    .NUM_EL (NUM_EL),
    .AW     (AW)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_inc  (w_inc),
    .o_addr (w_addr),
    .o_tc   (w_tc)
  );

  // Next-state decode: start only matters in IDLE, DRAIN lasts two cycles.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_tc) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (r_drain) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus status outputs, registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_drain <= 1'b0;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= (r_state == DRAIN);
      r_rd_en <= (w_state_nxt == RUN);
      r_busy  <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  assign w_a_ext = {a_data[N_BITS-1], a_data};
  assign w_b_ext = {b_data[N_BITS-1], b_data};

`ifdef MAT_ADD_SUB_EN
  logic r_sub;

  // Operation select is captured with an accepted start and frozen until the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sub <= 1'b0;
    end else if (w_load) begin
      r_sub <= sub;
    end else begin
      r_sub <= r_sub;
    end
  end

  assign w_sum = r_sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
`else
  assign w_sum = w_a_ext + w_b_ext;
`endif

  // Read pipeline: delay strobe/address to meet the returning RAM data, then
  // register the sum with its address as the write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_en   <= 1'b0;
      r_s2_addr <= {AW{1'b0}};
      r_wr_en   <= 1'b0;
      r_wr_addr <= {AW{1'b0}};
      r_wr_data <= {(N_BITS + 1){1'b0}};
    end else begin
      r_s2_en   <= r_rd_en;
      r_s2_addr <= w_addr;
      r_wr_en   <= r_s2_en;
      r_wr_addr <= r_s2_addr;
      if (r_s2_en) begin
        r_wr_data <= w_sum;
      end else begin
        r_wr_data <= r_wr_data;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_en   = r_rd_en;
  assign rd_addr = w_addr;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_mat_add_ctrl.sv
// Self-checking bench for mat_add_ctrl with a 2x3 matrix of 8-bit operands.
// Expected outputs come from the cycle-timing rules (start sampled in cycle 0)
// and plain integer arithmetic on the RAM contents.
module tb_mat_add_ctrl;

  localparam int SA     = 2;
  localparam int SB     = 3;
  localparam int NB     = 8;
  localparam int NUM_EL = SA * SB;
  localparam int AW     = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic signed [NB-1:0] a_data;
  logic signed [NB-1:0] b_data;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic signed [NB:0]   wr_data;
`ifdef MAT_ADD_SUB_EN
  logic                 sub;
`endif

  mat_add_ctrl #(
    .SIZE_A (SA),
    .SIZE_B (SB),
    .N_BITS (NB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .a_data  (a_data),
    .b_data  (b_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
`ifdef MAT_ADD_SUB_EN
    ,
    .sub     (sub)
`endif
  );

  always #5 clk = ~clk;

  logic signed [NB-1:0] mem_a [0:7];
  logic signed [NB-1:0] mem_b [0:7];
  int exp_mem [0:NUM_EL-1];
  int n_checks = 0;
  int n_errors = 0;
  bit cur_sub  = 1'b0;

  // Source RAMs: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= mem_a[rd_addr];
      b_data <= mem_b[rd_addr];
    end
  end

  typedef struct {
    int a;
    int b;
    int s;
  } vec_t;

  vec_t tbl [0:11];

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, expv, $time);
    end
  endtask

  // Element k gets operands a, b; expected result from the operation rule.
  task automatic load_elem(input int k, input int a, input int b);
    mem_a[k]   = NB'(a);
    mem_b[k]   = NB'(b);
    exp_mem[k] = cur_sub ? (a - b) : (a + b);
  endtask

  // Expected outputs for cycle c counted from the cycle start was sampled.
  task automatic check_cycle(input int c);
    bit e_rd;
    bit e_wr;
    bit e_busy;
    bit e_done;
    e_rd   = (c >= 1) && (c <= NUM_EL);
    e_wr   = (c >= 3) && (c <= NUM_EL + 2);
    e_busy = (c >= 1) && (c <= NUM_EL + 2);
    e_done = (c == NUM_EL + 3);
    chk("rd_en", rd_en, int'(e_rd));
    if (e_rd) chk("rd_addr", rd_addr, c - 1);
    chk("busy", busy, int'(e_busy));
    chk("done", done, int'(e_done));
    chk("wr_en", wr_en, int'(e_wr));
    if (e_wr) begin
      chk("wr_addr", wr_addr, c - 3);
      chk("wr_data", wr_data, exp_mem[c - 3]);
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_rd_en"}, rd_en, 0);
    chk({nm, "_rd_addr"}, rd_addr, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_wr_en"}, wr_en, 0);
    chk({nm, "_wr_addr"}, wr_addr, 0);
    chk({nm, "_wr_data"}, wr_data, 0);
  endtask

  // One operation: start in cycle 0, optional extra start pulse in cycle
  // extra_c, optional sub flip mid-run; checks through the following IDLE cycle.
  task automatic do_run(input int extra_c, input bit toggle_sub);
    @(posedge clk);
    #1;
    start = 1'b1;
`ifdef MAT_ADD_SUB_EN
    sub = cur_sub;
`endif
    for (int c = 1; c <= NUM_EL + 4; c++) begin
      @(posedge clk);
      #1;
      start = (c == extra_c);
`ifdef MAT_ADD_SUB_EN
      if (toggle_sub && (c == 3)) sub = ~sub;
`endif
      @(negedge clk);
      check_cycle(c);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    a_data = '0;
    b_data = '0;
`ifdef MAT_ADD_SUB_EN
    sub = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end

    // Table: run 0 is the basic sum, run 1 carries the extremes.
    for (int k = 0; k < NUM_EL; k++) tbl[k] = '{5, 3, 8};
    tbl[6]  = '{10, -20, -10};
    tbl[7]  = '{-1, -1, -2};
    tbl[8]  = '{-128, -128, -256};
    tbl[9]  = '{100, 27, 127};
    tbl[10] = '{127, 127, 254};
    tbl[11] = '{-128, 127, -1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NUM_EL; k++) begin
        mem_a[k]   = NB'(tbl[r * NUM_EL + k].a);
        mem_b[k]   = NB'(tbl[r * NUM_EL + k].b);
        exp_mem[k] = tbl[r * NUM_EL + k].s;
      end
      do_run(0, 1'b0);
    end

    // Start pulsed again in cycle 4 must be ignored.
    for (int k = 0; k < NUM_EL; k++) load_elem(k, 5, 3);
    do_run(4, 1'b0);

    // Start held high: runs at cycles 0 and 10, done in 9 and 19.
    for (int k = 0; k < NUM_EL; k++) load_elem(k, k * 7 - 20, 11 - k);
    @(posedge clk);
    #1;
    start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(posedge clk);
      #1;
      if (c == 12) start = 1'b0;
      @(negedge clk);
      check_cycle((c >= 10) ? (c - 10) : c);
    end

    // Randomized operands against the arithmetic model.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NUM_EL; k++) begin
        load_elem(k, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
      end
      do_run(0, 1'b0);
    end

    // Reset asserted in cycle 4 of a run: everything clears, no done.
    for (int k = 0; k < NUM_EL; k++) load_elem(k, 9, -4);
    @(posedge clk);
    #1;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (c == 4) rst_n = 1'b0;
      if (c == 6) rst_n = 1'b1;
      @(negedge clk);
      if (c <= 4) check_cycle(c);
      else check_all_zero("midrst");
    end
    do_run(0, 1'b0);

`ifdef MAT_ADD_SUB_EN
    cur_sub = 1'b1;
    for (int k = 0; k < NUM_EL; k++) load_elem(k, 5, 3);
    do_run(0, 1'b1);
    for (int k = 0; k < NUM_EL; k++) load_elem(k, -128, 127);
    do_run(0, 1'b0);
    cur_sub = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
